// File: rtl/mano_pkg.sv
// Shared definitions for the 16-line request encoder.
//   N                   number of request lines
//   IDX_W               width of an encoded request index
//   ROUND_ROBIN_DEFAULT default arbitration mode (0 = fixed, 1 = rotating)
//   state_e             offer FSM states
//   onehot()            4-to-16 decode, the inverse of the encoder
package mano_pkg;

    localparam int unsigned N     = 16;
    localparam int unsigned IDX_W = 4;

    localparam bit ROUND_ROBIN_DEFAULT = 1'b0;

    typedef enum logic [0:0] {
        StIdle,
        StOffer
    } state_e;

    function automatic logic [N-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/prio_enc16.sv
// Combinational 16-input priority encoder with a movable starting point.
//   vec  in  16  request vector
//   ptr  in  4   index searched first; the search wraps past 15 to 0
//   idx  out 4   first set index at or above ptr (mod 16)
//   any  out 1   at least one bit of vec is set
module prio_enc16
    import mano_pkg::*;
(
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic [IDX_W-1:0] enc;

    always_comb begin
        // Rotate so that bit ptr lands at position 0, then take the lowest set bit.
        dbl = {vec, vec};
        rot = dbl[ptr +: N];
        enc = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                enc = IDX_W'(i);
            end
        end
        // Undo the rotation; 4-bit arithmetic gives the wrap for free.
        idx = enc + ptr;
        any = |vec;
    end

endmodule

// File: rtl/encoder16x4_req.sv
// Collects request strobes into a pending register and offers them one at a time
// to the control sequencer as a registered 4-bit code with a valid/ack handshake.
//   clk         in   1   system clock
//   rst_n       in   1   asynchronous active-low reset
//   req         in   16  request set strobes
//   en          in   1   grant enable; gates new offers only
//   ack         in   1   control unit accepts the current code
//   code_o      out  4   encoded index of the offered request
//   valid_o     out  1   code_o is a valid offer
//   grant_oh_o  out  16  one-hot of code_o while valid_o, else 0
//   pending_o   out  16  pending register
//   multi_o     out  1   more than one pending bit set
module encoder16x4_req
    import mano_pkg::*;
#(
    parameter bit ROUND_ROBIN = ROUND_ROBIN_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    input  logic             ack,
    output logic [IDX_W-1:0] code_o,
    output logic             valid_o,
    output logic [N-1:0]     grant_oh_o,
    output logic [N-1:0]     pending_o,
    output logic             multi_o
);

    state_e           state_q, state_d;
    logic [N-1:0]     pending_q, pending_d;
    logic [IDX_W-1:0] code_q, code_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] enc_ptr;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_any;
    logic [N-1:0]     clr;

    // Fixed priority is just rotating priority with the start pinned at 0.
    assign enc_ptr = ROUND_ROBIN ? ptr_q : '0;

    prio_enc16 u_prio_enc16 (
        .vec (pending_q),
        .ptr (enc_ptr),
        .idx (sel_idx),
        .any (sel_any)
    );

    // Set has priority over clear for a bit requested in the same cycle it is acked.
    always_comb begin
        clr       = (valid_o && ack) ? grant_oh_o : '0;
        pending_d = (pending_q & ~clr) | req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            code_q    <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
            ptr_q     <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        case (state_q)
            StIdle: begin
                // Code is snapshotted here and frozen for the whole offer.
                if (en && sel_any) begin
                    state_d = StOffer;
                    code_d  = sel_idx;
                end
            end
            StOffer: begin
                // en is deliberately ignored: an offer is never withdrawn.
                if (ack) begin
                    state_d = StIdle;
                    if (ROUND_ROBIN) begin
                        ptr_d = code_q + IDX_W'(1);
                    end
                end
            end
        endcase
    end

    always_comb begin
        valid_o    = (state_q == StOffer);
        code_o     = code_q;
        grant_oh_o = valid_o ? onehot(code_q) : '0;
        pending_o  = pending_q;
        // x & (x-1) clears the lowest set bit; anything left means two or more.
        multi_o    = |(pending_q & (pending_q - {{(N-1){1'b0}}, 1'b1}));
    end

endmodule

// File: tb/tb_encoder16x4_req.sv
// Bench for encoder16x4_req: a fixed-priority and a round-robin instance share one
// stimulus stream and are both compared against a behavioural model after every edge.
module tb_encoder16x4_req;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        en;
    logic        ack;

    logic [3:0]  code_o     [2];
    logic        valid_o    [2];
    logic [15:0] grant_oh_o [2];
    logic [15:0] pending_o  [2];
    logic        multi_o    [2];

    int checks = 0;
    int errors = 0;

    // Reference model state, index 0 = fixed priority, 1 = round robin.
    logic [15:0] m_pend  [2];
    bit          m_valid [2];
    logic [3:0]  m_code  [2];
    logic [3:0]  m_ptr   [2];

    encoder16x4_req #(.ROUND_ROBIN(1'b0)) dut_fp (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .en         (en),
        .ack        (ack),
        .code_o     (code_o[0]),
        .valid_o    (valid_o[0]),
        .grant_oh_o (grant_oh_o[0]),
        .pending_o  (pending_o[0]),
        .multi_o    (multi_o[0])
    );

    encoder16x4_req #(.ROUND_ROBIN(1'b1)) dut_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .en         (en),
        .ack        (ack),
        .code_o     (code_o[1]),
        .valid_o    (valid_o[1]),
        .grant_oh_o (grant_oh_o[1]),
        .pending_o  (pending_o[1]),
        .multi_o    (multi_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // First set index scanning upward from start (wrapping) in RR mode, from 0 otherwise.
    function automatic logic [3:0] pick(input logic [15:0] p, input logic [3:0] start,
                                        input bit rr);
        for (int k = 0; k < 16; k++) begin
            int j;
            j = rr ? (int'(start) + k) % 16 : k;
            if (p[j]) return j[3:0];
        end
        return 4'd0;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_code[m]  = '0;
            m_ptr[m]   = '0;
        end
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            logic [15:0] clr;
            logic [15:0] nxt;
            clr = (m_valid[m] && ack) ? (16'h0001 << m_code[m]) : 16'h0000;
            nxt = (m_pend[m] & ~clr) | req;
            if (!m_valid[m]) begin
                if (en && m_pend[m] != 16'h0000) begin
                    m_code[m]  = pick(m_pend[m], m_ptr[m], m == 1);
                    m_valid[m] = 1'b1;
                end
            end else if (ack) begin
                m_valid[m] = 1'b0;
                if (m == 1) m_ptr[m] = 4'((int'(m_code[m]) + 1) % 16);
            end
            m_pend[m] = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            string p;
            p = (m == 1) ? "rr" : "fp";
            check({p, " valid"}, 32'(valid_o[m]), 32'(m_valid[m]));
            if (m_valid[m]) check({p, " code"}, 32'(code_o[m]), 32'(m_code[m]));
            check({p, " grant"}, 32'(grant_oh_o[m]),
                  m_valid[m] ? 32'(16'h0001 << m_code[m]) : 32'h0);
            check({p, " pending"}, 32'(pending_o[m]), 32'(m_pend[m]));
            check({p, " multi"}, 32'(multi_o[m]), 32'($countones(m_pend[m]) > 1));
        end
    endtask

    task automatic step(input logic [15:0] r, input bit e, input bit a);
        req = r;
        en  = e;
        ack = a;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        logic [3:0] rr_exp [4];
        rr_exp = '{4'd15, 4'd0, 4'd15, 4'd0};

        rst_n = 1'b0;
        req   = '0;
        en    = 1'b0;
        ack   = 1'b0;
        model_reset();
        #12;
        check_all();
        check("reset code", 32'(code_o[0]), 32'h0);
        rst_n = 1'b1;

        // Single request: two edges to offer, code 9.
        step(16'h0200, 1'b1, 1'b0);
        check("single early valid", 32'(valid_o[0]), 32'h0);
        step(16'h0000, 1'b1, 1'b0);
        check("single code", 32'(code_o[0]), 32'd9);
        check("single grant", 32'(grant_oh_o[0]), 32'h0200);
        step(16'h0000, 1'b1, 1'b1);
        check("single cleared", 32'(pending_o[0]), 32'h0);

        // Fixed priority order 0, 4, 15.
        step(16'h8011, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        check("fp first", 32'(code_o[0]), 32'd0);
        check("fp multi3", 32'(multi_o[0]), 32'h1);
        step(16'h0000, 1'b1, 1'b1);
        step(16'h0000, 1'b1, 1'b0);
        check("fp second", 32'(code_o[0]), 32'd4);
        step(16'h0000, 1'b1, 1'b1);
        step(16'h0000, 1'b1, 1'b0);
        check("fp third", 32'(code_o[0]), 32'd15);
        check("fp multi1", 32'(multi_o[0]), 32'h0);
        step(16'h0000, 1'b1, 1'b1);

        // Round robin alternation with both ends kept re-set; ptr starts at 5 here.
        step(16'h8001, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(16'h8001, 1'b1, 1'b0);
            check("rr alternate", 32'(code_o[1]), 32'(rr_exp[i]));
            step(16'h8001, 1'b1, 1'b1);
        end
        repeat (8) step(16'h0000, 1'b1, 1'b1);

        // Ack of code 3 coinciding with a new req[3].
        step(16'h0008, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        check("sim code3", 32'(code_o[0]), 32'd3);
        step(16'h0008, 1'b1, 1'b1);
        check("sim set wins", 32'(pending_o[0]), 32'h0008);
        step(16'h0000, 1'b1, 1'b0);
        check("sim reoffer", 32'(valid_o[0]), 32'h1);
        step(16'h0000, 1'b1, 1'b1);

        // Ack while idle changes nothing; en low blocks new offers.
        step(16'h0040, 1'b0, 1'b0);
        step(16'h0000, 1'b0, 1'b1);
        check("idle ack", 32'(pending_o[0]), 32'h0040);
        step(16'h0004, 1'b0, 1'b0);
        repeat (3) step(16'h0000, 1'b0, 1'b0);
        check("en low no offer", 32'(valid_o[0]), 32'h0);
        step(16'h0000, 1'b1, 1'b0);
        check("en offer code", 32'(code_o[0]), 32'd2);
        step(16'h0000, 1'b0, 1'b0);
        check("en drop held", 32'(valid_o[0]), 32'h1);
        step(16'h0000, 1'b0, 1'b1);
        repeat (8) step(16'h0000, 1'b1, 1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(16'($urandom) & 16'($urandom) & 16'($urandom),
                 ($urandom % 4) != 0, ($urandom % 2) == 1);
        end

        // Async reset in the middle of an offer of code 5.
        repeat (40) step(16'h0000, 1'b1, 1'b1);
        step(16'h0020, 1'b1, 1'b0);
        step(16'h0000, 1'b1, 1'b0);
        check("pre-reset code5", 32'(code_o[0]), 32'd5);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("async code", 32'(code_o[1]), 32'h0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) step(16'h0000, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
